// File: rtl/ce_cascade.sv
// Clock-enable generator: loadable down-counting prescaler feeding a cascade of modulo-STAGE_MOD stages.
// Runtime divisor loading (div_reg, DIV_LD, DIV_IN) exists only when CE_CASCADE_DIVLD_EN is defined.

module ce_cascade_stage #(
    parameter int unsigned STAGE_MOD = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic ce_i,
    output logic ce_o
);
    localparam int unsigned SW = $clog2(STAGE_MOD);
    localparam logic [SW-1:0] S_TOP = SW'(STAGE_MOD - 1);

    logic [SW-1:0] s_q, s_d;

    // Tick only when the upstream tick arrives on the wrap count, so all wraps align.
    assign ce_o = ce_i & (s_q == '0);

    always_comb begin
        s_d = s_q;
        if (clr_i)
            s_d = S_TOP;
        else if (ce_i)
            s_d = (s_q == '0) ? S_TOP : s_q - SW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            s_q <= S_TOP;
        else
            s_q <= s_d;
    end
endmodule

module ce_cascade #(
    parameter int unsigned      PRE_W       = 17,
    parameter logic [PRE_W-1:0] PRE_DEFAULT = PRE_W'(99999),
    parameter int unsigned      STAGES      = 2,
    parameter int unsigned      STAGE_MOD   = 10
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             CLR,
    input  logic             DIV_LD,
    input  logic [PRE_W-1:0] DIV_IN,
    output logic [STAGES:0]  CE
);
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] reload_val;
    logic [PRE_W-1:0] clr_val;

`ifdef CE_CASCADE_DIVLD_EN
    logic [PRE_W-1:0] div_q, div_d;

    assign div_d = DIV_LD ? DIV_IN : div_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            div_q <= PRE_DEFAULT;
        else
            div_q <= div_d;
    end

    // A zero-count reload uses the old divisor; a restart with a load takes the new one directly.
    assign reload_val = div_q;
    assign clr_val    = DIV_LD ? DIV_IN : div_q;
`else
    logic unused_div;

    assign unused_div = ^{DIV_LD, DIV_IN};
    assign reload_val = PRE_DEFAULT;
    assign clr_val    = PRE_DEFAULT;
`endif

    always_comb begin
        pre_d = pre_q;
        if (CLR)
            pre_d = clr_val;
        else if (EN)
            pre_d = (pre_q == '0) ? reload_val : pre_q - PRE_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            pre_q <= PRE_DEFAULT;
        else
            pre_q <= pre_d;
    end

    assign CE[0] = EN & ~CLR & (pre_q == '0);

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        ce_cascade_stage #(
            .STAGE_MOD(STAGE_MOD)
        ) u_stage (
            .clk_i (CLK),
            .rst_ni(RST_N),
            .clr_i (CLR),
            .ce_i  (CE[k-1]),
            .ce_o  (CE[k])
        );
    end
endmodule

// File: tb/tb_ce_cascade.sv
// Bench for ce_cascade: period/phase reference model checked every cycle plus literal timing pins.

module tb_ce_cascade;
    localparam int MODV = 10;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b1;
    logic        CLR = 1'b0;
    logic        DIV_LD = 1'b0;
    logic [16:0] DIV_IN = '0;
    logic [2:0]  CE;

    always #5 CLK = ~CLK;

    ce_cascade #(
        .PRE_W(17), .PRE_DEFAULT(17'd4), .STAGES(2), .STAGE_MOD(10)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR),
        .DIV_LD(DIV_LD), .DIV_IN(DIV_IN), .CE(CE)
    );

    // Reference: position inside the current prescale period, its length, and CE[0] ticks since restart.
    int     pos = 0;
    int     per = 5;
    int     dreg = 4;
    longint nt = 0;

    int     checks = 0;
    int     errors = 0;

    // Literal expectations are posted by the stimulus process and judged by the compare process.
    string  lit_name [0:63];
    int     lit_got  [0:63];
    int     lit_exp  [0:63];
    int     lit_wr = 0;
    int     lit_rd = 0;
    bit     done = 1'b0;

    function automatic logic [2:0] model_ce();
        logic [2:0] e;
        logic       t0;
        t0   = EN && !CLR && (pos == per - 1);
        e[0] = t0;
        e[1] = t0 && (((nt + 1) % MODV) == 0);
        e[2] = t0 && (((nt + 1) % (MODV * MODV)) == 0);
        return e;
    endfunction

    always @(negedge CLK) begin
        logic [2:0] exp_ce;
        while (lit_rd < lit_wr) begin
            checks++;
            if (lit_got[lit_rd] != lit_exp[lit_rd]) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d", lit_name[lit_rd], lit_got[lit_rd], lit_exp[lit_rd]);
            end
            lit_rd++;
        end
        if (!RST_N) begin
            pos = 0; per = 5; dreg = 4; nt = 0;
            exp_ce = 3'b000;
        end else begin
            exp_ce = model_ce();
        end
        checks++;
        if (CE !== exp_ce) begin
            errors++;
            $display("FAIL ce_model @%0t: CE=%b expected %b (pos=%0d per=%0d nt=%0d)", $time, CE, exp_ce, pos, per, nt);
        end
        if (RST_N) begin
            if (CLR) begin
                pos = 0; nt = 0;
`ifdef CE_CASCADE_DIVLD_EN
                per = (DIV_LD ? int'(DIV_IN) : dreg) + 1;
`else
                per = dreg + 1;
`endif
            end else if (EN) begin
                if (pos == per - 1) begin
                    pos = 0; per = dreg + 1; nt++;
                end else begin
                    pos++;
                end
            end
`ifdef CE_CASCADE_DIVLD_EN
            if (DIV_LD) dreg = int'(DIV_IN);
`endif
        end
        if (done && lit_rd == lit_wr) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic lit(input string n, input int got, input int exp_v);
        lit_name[lit_wr] = n;
        lit_got[lit_wr]  = got;
        lit_exp[lit_wr]  = exp_v;
        lit_wr++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Edges until CE[k] is seen high; -1 if the bound expires.
    task automatic wait_ce(input int k, input int maxe, output int n);
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!CE[k] && n < maxe);
        if (!CE[k]) n = -1;
    endtask

    task automatic do_reset();
        EN = 1'b1; CLR = 1'b0; DIV_LD = 1'b0;
        RST_N = 1'b0;
        tick(2);
        RST_N = 1'b1;
    endtask

    initial begin
        int n, n2;
        tick(2);
        lit("reset_ce", int'(CE), 0);
        RST_N = 1'b1;
        wait_ce(0, 20, n);   lit("first_ce0", n, 4);
        wait_ce(0, 20, n);   lit("ce0_period", n, 5);

        do_reset();
        wait_ce(1, 100, n);  lit("first_ce1", n, 49);
        wait_ce(1, 100, n);  lit("ce1_period", n, 50);
        do_reset();
        wait_ce(2, 1000, n); lit("first_ce2", n, 499);
        wait_ce(2, 1000, n); lit("ce2_period", n, 500);

        do_reset();
        tick(2);
        EN = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            lit("en_gap_ce", int'(CE), 0);
        end
        EN = 1'b1;
        wait_ce(0, 20, n);   lit("en_resume_ce0", n, 2);

        do_reset();
        tick(4);
        lit("pre_clr_ce0", int'(CE[0]), 1);
        CLR = 1'b1;
        #1;
        lit("clr_cycle_ce", int'(CE), 0);
        tick(1);
        CLR = 1'b0;
        wait_ce(0, 20, n);   lit("clr_first_ce0", n, 4);
        wait_ce(1, 100, n2); lit("clr_first_ce1", (n < 0 || n2 < 0) ? -1 : n + n2, 49);

        do_reset();
        tick(1);
        DIV_IN = 17'd9; DIV_LD = 1'b1;
        tick(1);
        DIV_LD = 1'b0;
        wait_ce(0, 30, n);   lit("divld_cur_end", (n < 0) ? -1 : n + 1, 3);
`ifdef CE_CASCADE_DIVLD_EN
        wait_ce(0, 30, n);   lit("divld_new_ce0", n, 10);
        wait_ce(1, 200, n);
        wait_ce(1, 200, n);  lit("divld_new_ce1", n, 100);

        DIV_IN = 17'd0; DIV_LD = 1'b1; CLR = 1'b1;
        tick(1);
        DIV_LD = 1'b0; CLR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lit("d0_ce0", int'(CE[0]), 1);
            tick(1);
        end
        wait_ce(1, 50, n);
        wait_ce(1, 50, n);   lit("d0_ce1", n, 10);
        wait_ce(2, 300, n);
        wait_ce(2, 300, n);  lit("d0_ce2", n, 100);

        DIV_IN = 17'd9; DIV_LD = 1'b1;
        tick(1);
        DIV_LD = 1'b0;
        wait_ce(0, 30, n);
        wait_ce(0, 30, n);   lit("reload9_ce0", n, 10);
`else
        wait_ce(0, 30, n);   lit("divld_ignored", n, 5);
`endif
        wait_ce(0, 30, n);
        RST_N = 1'b0;
        #1;
        lit("rst_async_ce", int'(CE), 0);
        tick(1);
        RST_N = 1'b1;
        wait_ce(0, 30, n);   lit("rst_first_ce0", n, 4);
        wait_ce(0, 30, n);   lit("rst_period", n, 5);

        for (int i = 0; i < 4000; i++) begin
            EN     = ($urandom % 8) != 0;
            CLR    = ($urandom % 64) == 0;
            DIV_LD = ($urandom % 50) == 0;
            DIV_IN = 17'($urandom_range(0, 6));
            RST_N  = ($urandom % 700) != 0;
            tick(1);
            RST_N  = 1'b1;
        end
        EN = 1'b1; CLR = 1'b0; DIV_LD = 1'b0;
        tick(3);
        done = 1'b1;
        tick(10);
        $display("FAIL summary_timeout: compare process did not finish");
        $fatal(1);
    end
endmodule
